// File: rtl/cs_pkg.sv
// Shared types and constants for the chip-select round-robin sequencer.
package cs_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/cs_decode3to8.sv
// 3-to-8 active-low select decoder with active-high enable.
module cs_decode3to8
    import cs_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] sel_n
);

    always_comb begin
        sel_n = '1;
        if (en) begin
            sel_n[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/cs_rr_sequencer.sv
// Round-robin chip-select sequencer with break-before-make gap.
// Hold timeout is built only when CS_RR_SEQUENCER_TIMEOUT_EN is defined.
module cs_rr_sequencer
    import cs_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic             done,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid,
    output logic [7:0]       gnt_n,
    output logic             busy,
    output logic             timeout
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES out of range");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [NUM_REQ-1:0] gnt_n_q, gnt_n_d;
    logic [3:0]         gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               rel_req;
    logic               rel_tmo;

    // Search upward from last+1; 3-bit addition wraps 7 -> 0.
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req[last_q + IDX_W'(k)]) begin
                win_idx   = last_q + IDX_W'(k);
                win_found = 1'b1;
            end
        end
    end

    assign rel_req = done || !req[gnt_idx_q];

`ifdef CS_RR_SEQUENCER_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic [8:0] hold_nxt;

    assign hold_nxt = {1'b0, hold_q} + 9'd1;
    assign rel_tmo  = !rel_req && (hold_nxt == 9'(MAX_HOLD));
    assign hold_d   = (state_q == GRANT) ? hold_nxt[7:0] : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign rel_tmo = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        gnt_valid_d = gnt_valid_q;
        gap_d       = gap_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = win_idx;
                    last_d      = win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (rel_req || rel_tmo) begin
                    state_d     = GAP;
                    gnt_valid_d = 1'b0;
                    gap_d       = 4'(GAP_CYCLES - 1);
                    timeout_d   = rel_tmo;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    cs_decode3to8 u_dec (
        .idx   (gnt_idx_d),
        .en    (gnt_valid_d),
        .sel_n (gnt_n_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            last_q      <= 3'd7;
            gnt_valid_q <= 1'b0;
            gnt_n_q     <= 8'hFF;
            gap_q       <= 4'd0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_q      <= last_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_n_q     <= gnt_n_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_n     = gnt_n_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cs_rr_sequencer.sv
// Scoreboard bench for cs_rr_sequencer; the timeout scenario is
// exercised only when CS_RR_SEQUENCER_TIMEOUT_EN is defined.
module tb_cs_rr_sequencer;

    localparam int GAP = 2;
    localparam int MH  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] gnt_n;
    logic       busy;
    logic       timeout;

    cs_rr_sequencer #(.GAP_CYCLES(GAP), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_n     (gnt_n),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       idx;
        bit       valid;
        bit [7:0] gn;
        bit       busy;
        bit       to;
        bit       rst;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   total = 0;
    int   bad   = 0;
    int   to_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: owner/-1, remaining gap cycles, last winner.
    int m_owner, m_gap, m_last, m_idx, m_hold;
    bit m_to, m_rel, m_tmo;
    exp_t m_e;

    always @(posedge clk) begin
        m_e.rst = 1'b0;
        if (!rst_n) begin
            m_owner = -1; m_gap = 0; m_last = 7;
            m_idx = 0; m_hold = 0; m_to = 0;
            m_e.rst = 1'b1;
        end else begin
            m_to = 0;
            if (m_owner >= 0) begin
                m_rel = done || !req[m_owner];
                m_tmo = 0;
                m_hold++;
`ifdef CS_RR_SEQUENCER_TIMEOUT_EN
                if (!m_rel && m_hold >= MH) begin
                    m_rel = 1; m_tmo = 1;
                end
`endif
                if (m_rel) begin
                    m_owner = -1; m_gap = GAP; m_to = m_tmo;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (req != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                    end
                end
                m_idx = m_owner; m_last = m_owner; m_hold = 0;
            end
        end
        m_e.idx   = m_idx;
        m_e.valid = (m_owner >= 0);
        m_e.gn    = m_e.valid ? ~(8'h01 << m_idx) : 8'hFF;
        m_e.busy  = m_e.valid || (m_gap > 0);
        m_e.to    = m_to;
        sbq.push_back(m_e);
    end

    // Monitor: pop one expectation per cycle, plus grant log and gap checks.
    bit   prev_valid = 0;
    bit   have_prev  = 0;
    int   idle_run   = 0;
    exp_t e;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            chk("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            chk("gnt_n", 32'(gnt_n), 32'(e.gn));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("timeout", 32'(timeout), 32'(e.to));
            chk("onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
            if (timeout === 1'b1) to_cnt++;
            if (e.rst) begin
                have_prev = 0;
                idle_run  = 0;
            end else if (gnt_valid && !prev_valid) begin
                glog.push_back(int'(gnt_idx));
                if (have_prev) begin
                    chk("gap_len_ok", 32'(idle_run >= GAP + 1), 32'd1);
                end
                have_prev = 1;
                idle_run  = 0;
            end else if (!gnt_valid) begin
                idle_run++;
            end
            prev_valid = gnt_valid;
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant();
        int i;
        for (i = 0; i < 60; i++) begin
            if (gnt_valid === 1'b1) break;
            cyc();
        end
        if (i == 60) begin
            total++; bad++;
            $display("FAIL wait_grant timed out t=%0t", $time);
        end
    endtask

    task automatic grant_done_after3();
        wait_grant();
        cyc(2);
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    task automatic chk_log(string nm, int exp[$]);
        chk({nm, "_len"}, 32'(glog.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < glog.size()) chk(nm, 32'(glog[i]), 32'(exp[i]));
        end
    endtask

    int t0;

    initial begin
        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);

        glog.delete();
        req = 8'h81;
        repeat (4) grant_done_after3();
        req = 8'h00;
        cyc(8);
        chk_log("order_81", '{0, 7, 0, 7});

        glog.delete();
        req = 8'hFF;
        repeat (9) grant_done_after3();
        req = 8'h00;
        cyc(8);
        chk_log("order_ff", '{0, 1, 2, 3, 4, 5, 6, 7, 0});

        req = 8'h08;
        wait_grant();
        chk("grant3_idx", 32'(gnt_idx), 32'd3);
        cyc();
        req = 8'h00;
        cyc();
        chk("drop_gnt_n", 32'(gnt_n), 32'hFF);
        chk("drop_busy", 32'(busy), 32'd1);
        cyc(6);

`ifdef CS_RR_SEQUENCER_TIMEOUT_EN
        t0 = to_cnt;
        req = 8'h04;
        wait_grant();
        cyc(MH + 2);
        req = 8'h00;
        cyc(6);
        chk("timeout_pulses", 32'(to_cnt - t0), 32'd1);
        t0 = to_cnt;
        req = 8'h04;
        wait_grant();
        cyc(MH - 1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        req = 8'h00;
        cyc(6);
        chk("done_wins", 32'(to_cnt - t0), 32'd0);
`endif

        req = 8'h20;
        wait_grant();
        chk("grant5_idx", 32'(gnt_idx), 32'd5);
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("rst_gnt_n", 32'(gnt_n), 32'hFF);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", 32'(gnt_valid), 32'd1);
        chk("post_rst_idx", 32'(gnt_idx), 32'd5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom);
            done  = ($urandom_range(5) == 0);
            rst_n = ($urandom_range(299) != 0);
            cyc();
        end
        rst_n = 1'b1; done = 1'b0; req = 8'h00;
        cyc(8);

`ifndef CS_RR_SEQUENCER_TIMEOUT_EN
        chk("no_timeout", 32'(to_cnt), 32'd0);
`endif
        chk("sb_drained", 32'(sbq.size() <= 1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cs_rr_sequencer.md
Name: cs_rr_sequencer

Overview:
Round-robin arbiter and sequencer sharing one 3-to-8 active-low select decoder among 8 requesters. It registers a 3-bit grant index and drives eight active-low chip-selects, one at a time. It inserts break-before-make dead time between grants and optionally enforces a hold timeout. It sits between bus masters and the chip-select fan-out.

Parameters:
GAP_CYCLES, 1, dead cycles with all selects high between grants; legal range 1..15.
MAX_HOLD, 16, maximum grant cycles before forced release (only used with the optional feature); legal range 1..255.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
req  input  8  request vector; req[i] asks for select i
done  input  1  single-cycle pulse from the current owner releasing the grant
gnt_idx  output  3  registered index of the current owner
gnt_valid  output  1  registered; high while a grant is held
gnt_n  output  8  registered active-low one-hot select; all ones when gnt_valid=0
busy  output  1  high in GRANT or GAP
timeout  output  1  single-cycle pulse on forced release; constant 0 without the optional feature

Behaviour:
- Synchronous active-low reset on clk; rst_n sampled low at a rising edge resets the block. The polarity and synchronicity are fixed.
- Reset values: state=IDLE, gnt_idx=0, gnt_valid=0, gnt_n=8'hFF, busy=0, timeout=0, internal last pointer=7 (first priority goes to requester 0).
- States: IDLE, GRANT, GAP.
- IDLE -> GRANT: at least one req bit is high at an edge.
  - Winner is the first set bit searching upward from (last+1) mod 8, wrapping 7->0.
  - On the same edge: gnt_idx=winner, last=winner, gnt_valid=1, gnt_n[winner]=0.
  - Latency: one cycle from req sampled in IDLE to the select asserted.
- GRANT -> GAP: done=1, or req[gnt_idx]=0, at an edge.
  - On that edge gnt_valid=0 and gnt_n=8'hFF; gnt_idx holds its value.
  - Other requests are ignored during GRANT.
- GAP: lasts exactly GAP_CYCLES cycles, counted by a 4-bit down-counter, then goes to IDLE. Requests during GAP are held, not lost; arbitration happens in IDLE.
- Consequence: back-to-back grants are separated by at least GAP_CYCLES+1 cycles with all selects high (GAP_CYCLES in GAP plus one IDLE cycle).
- done outside GRANT is ignored.
- gnt_n never has more than one bit low. gnt_n equals the decode of gnt_idx when gnt_valid=1.
- Reset asserted mid-GRANT or mid-GAP returns all outputs to reset values at that edge; no gap is enforced after reset.
- busy=1 in GRANT and GAP, 0 in IDLE.

Optional Feature:
Macro CS_RR_SEQUENCER_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD with neither done nor the req drop seen, the block goes GRANT->GAP as for a normal release and pulses timeout=1 for exactly one cycle on the first GAP cycle.
  - If done and timeout coincide, done wins and there is no timeout pulse.
- Undefined: no counter is built; the grant is held indefinitely until done or the req drop; timeout is tied to 0.

Decomposition:
- Shared package cs_pkg holds:
  - the state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2);
  - the constants NUM_REQ=8 and IDX_W=3.
- One sub-module, cs_decode3to8: combinational 3-to-8 active-low decoder with an active-high enable. It is instantiated once, and its output is registered into gnt_n.
- The round-robin priority search stays inline.

Test Plan:
- Reset, then req=8'h00 for 10 cycles -> gnt_n=8'hFF, gnt_valid=0, busy=0 throughout.
- req=8'h81 held, done pulsed 3 cycles after each grant -> grant order 0,7,0,7; gnt_n alternates 8'hFE/8'h7F; at least GAP_CYCLES+1 all-high cycles between grants.
- req=8'hFF with done each grant -> gnt_idx sequence 0,1,...,7,0 (wrap-around); never two low bits in gnt_n.
- Grant to 3, then req[3] dropped with no done -> gnt_n=8'hFF on the next edge, state GAP.
- With the macro, MAX_HOLD=4 and no done -> release after 4 grant cycles and one timeout pulse; with done on cycle 4 -> no timeout pulse.
- rst_n driven low during GRANT of idx 5 -> next edge gnt_n=8'hFF, gnt_idx=0; after release with req=8'h20 -> grant 5 one cycle later.
